// File: rtl/config_idle_ctrl_if.sv
// ---------------------------------------------------------------------------
// config_idle_ctrl_if
// Signal bundle between the LTSSM / TX idle datapath side and the
// Configuration.Idle controller.
//   master : LTSSM side. It drives start, abort, back_pressure,
//            rx_idle_valid and rx_idle, and it observes the controller outputs.
//   slave  : the controller. It drives tx_idle_req, idl_clr, busy, l0_go and
//            timeout_go.
// ---------------------------------------------------------------------------
interface config_idle_ctrl_if;
    logic start;          // one-cycle pulse: enter Configuration.Idle
    logic abort;          // force return to OFF, highest priority
    logic back_pressure;  // TX cannot accept a symbol this cycle
    logic rx_idle_valid;  // received symbol valid this cycle
    logic rx_idle;        // received symbol is IDLE (qualified by valid)
    logic tx_idle_req;    // drive IDLE data on TX
    logic idl_clr;        // one-cycle clear pulse to idle-counting datapath
    logic busy;           // controller not in OFF
    logic l0_go;          // one-cycle pulse: exit to L0
    logic timeout_go;     // one-cycle pulse: exit to Detect

    modport master (
        output start, abort, back_pressure, rx_idle_valid, rx_idle,
        input  tx_idle_req, idl_clr, busy, l0_go, timeout_go
    );

    modport slave (
        input  start, abort, back_pressure, rx_idle_valid, rx_idle,
        output tx_idle_req, idl_clr, busy, l0_go, timeout_go
    );
endinterface

// File: rtl/config_idle_ctrl.sv
// ---------------------------------------------------------------------------
// config_idle_ctrl
// Sequences the Configuration.Idle substate. On start the controller requests
// continuous IDLE transmission. It counts the IDLEs actually sent after the
// first received IDLE, and it counts consecutive received IDLEs. When both
// targets are reached it pulses l0_go. If the timeout budget runs out first it
// pulses timeout_go.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - config_idle_ctrl_if.slave (start/abort/back_pressure/rx_idle_valid/
//          rx_idle in; tx_idle_req/idl_clr/busy/l0_go/timeout_go out)
// ---------------------------------------------------------------------------
module config_idle_ctrl #(
    parameter int TX_IDLE_REQ    = 16,
    parameter int RX_IDLE_REQ    = 8,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TO_WIDTH       = 19
) (
    input  logic               clk,
    input  logic               rst,
    config_idle_ctrl_if.slave  bus
);

    localparam int TX_W = $clog2(TX_IDLE_REQ) + 1;
    localparam int RX_W = $clog2(RX_IDLE_REQ) + 1;

    localparam logic [TX_W-1:0]     TX_MAX  = TX_W'(TX_IDLE_REQ);
    localparam logic [RX_W-1:0]     RX_MAX  = RX_W'(RX_IDLE_REQ);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TX_W-1:0]     TX_ONE  = TX_W'(1);
    localparam logic [RX_W-1:0]     RX_ONE  = RX_W'(1);
    localparam logic [TO_WIDTH-1:0] TO_ONE  = TO_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_EXIT_L0 = 2'd2,
        ST_EXIT_TO = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [TX_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [RX_W-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [TO_WIDTH-1:0] to_cnt_reg, to_cnt_next;
    logic                rx_seen_reg, rx_seen_next;

    logic tx_idle_req_c;
    logic idl_clr_c;
    logic busy_c;
    logic l0_go_c;
    logic timeout_go_c;

    logic rx_good;
    assign rx_good = bus.rx_idle_valid && bus.rx_idle;

    // State register and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_OFF;
            tx_cnt_reg  <= '0;
            rx_cnt_reg  <= '0;
            to_cnt_reg  <= '0;
            rx_seen_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tx_cnt_reg  <= tx_cnt_next;
            rx_cnt_reg  <= rx_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            rx_seen_reg <= rx_seen_next;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next    = state_reg;
        tx_idle_req_c = 1'b0;
        idl_clr_c     = 1'b0;
        busy_c        = 1'b0;
        l0_go_c       = 1'b0;
        timeout_go_c  = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (bus.start && !bus.abort) begin
                    state_next = ST_ACTIVE;
                    idl_clr_c  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                tx_idle_req_c = 1'b1;
                busy_c        = 1'b1;
                // Exit is judged on the registered counts. When the L0
                // criteria and the last timeout cycle coincide, L0 wins.
                if ((tx_cnt_reg == TX_MAX) && (rx_cnt_reg == RX_MAX)) begin
                    state_next = ST_EXIT_L0;
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next = ST_EXIT_TO;
                end
            end
            ST_EXIT_L0: begin
                busy_c     = 1'b1;
                l0_go_c    = 1'b1;
                state_next = ST_OFF;
            end
            ST_EXIT_TO: begin
                busy_c       = 1'b1;
                timeout_go_c = 1'b1;
                state_next   = ST_OFF;
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase

        if (bus.abort) begin
            state_next = ST_OFF;
        end
    end

    // Counter updates
    always_comb begin
        tx_cnt_next  = tx_cnt_reg;
        rx_cnt_next  = rx_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        rx_seen_next = rx_seen_reg;

        if (bus.abort || (state_reg == ST_OFF)) begin
            tx_cnt_next  = '0;
            rx_cnt_next  = '0;
            to_cnt_next  = '0;
            rx_seen_next = 1'b0;
        end else if (state_reg == ST_ACTIVE) begin
            to_cnt_next = to_cnt_reg + TO_ONE;

            // Gated by the registered flag. The IDLE sent in the cycle of
            // the first received IDLE is therefore not counted.
            if (tx_idle_req_c && !bus.back_pressure && rx_seen_reg &&
                (tx_cnt_reg != TX_MAX)) begin
                tx_cnt_next = tx_cnt_reg + TX_ONE;
            end

            if (bus.rx_idle_valid) begin
                if (bus.rx_idle) begin
                    if (rx_cnt_reg != RX_MAX) begin
                        rx_cnt_next = rx_cnt_reg + RX_ONE;
                    end
                end else begin
                    rx_cnt_next = '0;
                end
            end

            if (rx_good) begin
                rx_seen_next = 1'b1;
            end
        end
    end

    // The state is OFF during reset. idl_clr is the only output that also
    // depends on an input, so it is qualified by rst to keep it low in reset.
    assign bus.tx_idle_req = tx_idle_req_c;
    assign bus.idl_clr     = idl_clr_c && rst;
    assign bus.busy        = busy_c;
    assign bus.l0_go       = l0_go_c;
    assign bus.timeout_go  = timeout_go_c;

endmodule

// File: tb/tb_config_idle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_config_idle_ctrl
// Bench for config_idle_ctrl, run with a shortened timeout budget of 100 cycles.
// It combines a vector table, directed scenarios and random traffic. All of
// these are checked against a behavioural model of the substate rules.
// ---------------------------------------------------------------------------
module tb_config_idle_ctrl;

    localparam int TB_TX = 16;
    localparam int TB_RX = 8;
    localparam int TB_T  = 100;

    logic clk;
    logic rst;

    config_idle_ctrl_if bus();

    config_idle_ctrl #(
        .TX_IDLE_REQ   (TB_TX),
        .RX_IDLE_REQ   (TB_RX),
        .TIMEOUT_CYCLES(TB_T),
        .TO_WIDTH      (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=off, 1=active, 2=exit-to-L0, 3=exit-to-Detect
    int m_mode, m_tx, m_rx, m_to;
    bit m_seen;

    logic [4:0] obs;   // {tx_idle_req, idl_clr, busy, l0_go, timeout_go}

    function automatic logic [4:0] model_out(input logic s, input logic a);
        logic [4:0] r;
        r[4] = (m_mode == 1);
        r[3] = (m_mode == 0) && s && !a;
        r[2] = (m_mode != 0);
        r[1] = (m_mode == 2);
        r[0] = (m_mode == 3);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_tx = 0; m_rx = 0; m_to = 0; m_seen = 0;
    endtask

    task automatic model_update(input logic s, a, bp, rv, ri);
        int nm;
        if (a) begin
            model_reset();
        end else if (m_mode == 0) begin
            model_reset();
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            nm = 1;
            if (m_tx == TB_TX && m_rx == TB_RX) nm = 2;
            else if (m_to == TB_T - 1) nm = 3;
            m_to = m_to + 1;
            if (m_seen && !bp && m_tx < TB_TX) m_tx = m_tx + 1;
            if (rv) m_rx = ri ? ((m_rx < TB_RX) ? m_rx + 1 : m_rx) : 0;
            if (rv && ri) m_seen = 1;
            m_mode = nm;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic chk_vec(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs {txreq,clr,busy,l0,to} got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle. The task drives the inputs at the falling edge, samples
    // the outputs 1 time unit later, and advances the model after the rising edge.
    task automatic step(input logic s, a, bp, rv, ri,
                        input bit use_tab, input logic [4:0] tab_exp, input string nm);
        logic [4:0] exp;
        @(negedge clk);
        bus.start = s; bus.abort = a; bus.back_pressure = bp;
        bus.rx_idle_valid = rv; bus.rx_idle = ri;
        #1;
        obs = {bus.tx_idle_req, bus.idl_clr, bus.busy, bus.l0_go, bus.timeout_go};
        exp = use_tab ? tab_exp : model_out(s, a);
        chk_vec(nm, obs, exp);
        @(posedge clk);
        model_update(s, a, bp, rv, ri);
    endtask

    // Directed scenario. The start pulse is given at i=0. The returned
    // latencies are cycle indices relative to start (-1 if the pulse never came).
    task automatic run_scen(input int kind, output int lat_l0, output int lat_to,
                            output int n_l0, output int n_to);
        logic s, bp, rv, ri;
        lat_l0 = -1; lat_to = -1; n_l0 = 0; n_to = 0;
        for (int i = 0; i < 300; i++) begin
            s = (i == 0);
            bp = 1'b0;
            case (kind)
                0: begin rv = (i >= 1); ri = rv; end
                1: begin rv = (i >= 1); ri = rv; bp = (i % 2 == 0); end
                2: begin rv = (i >= 1 && i <= 8) || (i >= 20); ri = rv && (i != 8); end
                3: begin rv = (i % 3 == 0); ri = 1'b0; end
                default: begin rv = (i >= 83 && i <= 90); ri = rv; end
            endcase
            step(s, 1'b0, bp, rv, ri, 1'b0, 5'b0, $sformatf("scen%0d_c%0d", kind, i));
            if (obs[1]) begin n_l0++; if (lat_l0 < 0) lat_l0 = i; end
            if (obs[0]) begin n_to++; if (lat_to < 0) lat_to = i; end
            if ((lat_l0 >= 0 && i > lat_l0 + 4) || (lat_to >= 0 && i > lat_to + 4)) break;
        end
    endtask

    typedef struct {
        logic s, a, bp, rv, ri;
        logic [4:0] exp;
    } vec_t;

    vec_t tab[11];

    int l0a, toa, nl0, nto, l0b, tob, lat_tmp, n_tmp;

    initial begin
        // Each table row holds the inputs s, a, bp, rv, ri and the expected
        // outputs {tx_idle_req, idl_clr, busy, l0_go, timeout_go}.
        tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};  // idle in OFF
        tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000};  // start -> idl_clr
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10100};  // ACTIVE
        tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10100};  // start ignored
        tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10100};  // abort
        tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};  // abort beats start
        tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
        tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01000};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10100};
        tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10100};
        tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};

        // Reset
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.back_pressure = 1'b0;
        bus.rx_idle_valid = 1'b0; bus.rx_idle = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        chk_vec("reset_outputs", {bus.tx_idle_req, bus.idl_clr, bus.busy, bus.l0_go, bus.timeout_go}, 5'b00000);
        bus.start = 1'b0;
        rst = 1'b1;

        // Vector table
        for (int k = 0; k < 11; k++) begin
            step(tab[k].s, tab[k].a, tab[k].bp, tab[k].rv, tab[k].ri, 1'b1, tab[k].exp,
                 $sformatf("table%0d", k));
        end

        // Continuous IDLE traffic without back-pressure
        run_scen(0, l0a, toa, nl0, nto);
        chk_int("nobp_l0_latency", l0a, 19);
        chk_int("nobp_l0_count", nl0, 1);
        chk_int("nobp_timeout_count", nto, 0);

        // Back-pressure every other cycle adds 16 cycles
        run_scen(1, l0b, tob, nl0, nto);
        chk_int("bp_extra_cycles", l0b - l0a, 16);
        chk_int("bp_l0_count", nl0, 1);

        // An interrupted run of received IDLEs restarts the rx count
        run_scen(2, lat_tmp, tob, nl0, nto);
        chk_int("rx_restart_l0_latency", lat_tmp, 29);
        chk_int("rx_restart_l0_count", nl0, 1);

        // No received IDLE at all, so the timeout fires
        run_scen(3, lat_tmp, tob, nl0, nto);
        chk_int("timeout_latency", tob, TB_T + 1);
        chk_int("timeout_l0_count", nl0, 0);
        chk_int("timeout_count", nto, 1);

        // The L0 criteria are met in the final timeout cycle, so L0 wins
        run_scen(4, lat_tmp, tob, nl0, nto);
        chk_int("coincide_l0_latency", lat_tmp, TB_T + 1);
        chk_int("coincide_timeout_count", nto, 0);

        // Abort with 10 IDLEs already counted on tx
        n_tmp = 0;
        for (int i = 0; i < 16; i++) begin
            step(i == 0, i == 12, 1'b0, i >= 1, i >= 1, 1'b0, 5'b0, $sformatf("abort_c%0d", i));
            if (obs[1] || obs[0]) n_tmp++;
            if (i == 13) chk_vec("abort_off_next", obs, 5'b00000);
        end
        chk_int("abort_no_exit_pulse", n_tmp, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, "restart_start");
        chk_int("restart_idl_clr", int'(obs[3]), 1);
        run_scen(0, lat_tmp, tob, nl0, nto);
        chk_int("restart_from_zero_latency", lat_tmp, 19);

        // Reset asserted during ACTIVE
        for (int i = 0; i < 6; i++) step(i == 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b0, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_vec("midactive_reset", {bus.tx_idle_req, bus.idl_clr, bus.busy, bus.l0_go, bus.timeout_go}, 5'b00000);
        model_reset();
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0, 1'b0, 5'b0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_idle_ctrl.md
Name: config_idle_ctrl

Overview:
Sequences the Configuration.Idle substate of the LTSSM on the TX/RX path. On start it requests continuous IDLE transmission, counts IDLEs actually sent (honouring back-pressure) and consecutive IDLEs received, and signals exit to L0 when the exit criteria are met. If the criteria are not met in time, it signals a timeout toward Detect. Sits between the LTSSM and the TX idle-generation datapath.

Parameters:
TX_IDLE_REQ, 16, IDLEs that must be sent after the first received IDLE
RX_IDLE_REQ, 8, consecutive received IDLEs required
TIMEOUT_CYCLES, 500000, cycles before timeout (2 ms at 250 MHz)
TO_WIDTH, 19, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from LTSSM: enter Configuration.Idle
abort  in  1  LTSSM forces return to OFF, highest priority
back_pressure  in  1  TX cannot accept a symbol this cycle
rx_idle_valid  in  1  received symbol valid this cycle
rx_idle  in  1  received symbol is IDLE (qualified by rx_idle_valid)
tx_idle_req  out  1  drive IDLE data on TX (cnt_enable to idle datapath)
idl_clr  out  1  one-cycle clear pulse to the idle-counting datapath
busy  out  1  controller not in OFF
l0_go  out  1  one-cycle pulse: exit to L0
timeout_go  out  1  one-cycle pulse: exit to Detect

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low. In reset, all counters = 0, state = OFF, and all outputs = 0.
- States:
  - OFF: outputs 0. If start=1 -> ACTIVE; idl_clr=1 in that same cycle. Clear all counters.
  - ACTIVE: tx_idle_req=1, busy=1.
  - EXIT_L0: l0_go=1 for one cycle, then -> OFF.
  - EXIT_TO: timeout_go=1 for one cycle, then -> OFF.
- tx counter (width clog2(TX_IDLE_REQ)+1):
  - Increments when state=ACTIVE, tx_idle_req=1, back_pressure=0 and rx_seen=1. Saturates at TX_IDLE_REQ.
  - rx_seen is a flag set by the first cycle with rx_idle_valid && rx_idle in ACTIVE.
  - The tx increment is gated by the registered rx_seen, so the IDLE sent in the same cycle as the first received IDLE is not counted.
- rx counter (width clog2(RX_IDLE_REQ)+1):
  - rx_idle_valid && rx_idle: increment, saturating at RX_IDLE_REQ.
  - rx_idle_valid && !rx_idle: reset to 0. rx_seen is unaffected.
  - !rx_idle_valid: hold.
- Timeout counter: increments every ACTIVE cycle.
- ACTIVE exit, evaluated on registered counts:
  - tx_cnt==TX_IDLE_REQ and rx_cnt==RX_IDLE_REQ -> EXIT_L0.
  - Else if timeout count == TIMEOUT_CYCLES-1 -> EXIT_TO.
  - If both hold in the same cycle, L0 wins.
- abort: in any state, next state = OFF, counters cleared, no l0_go/timeout_go pulse. abort beats start.
- start while busy is ignored.
- Latency:
  - start -> tx_idle_req high 1 cycle later.
  - The last qualifying count update -> l0_go 2 cycles later: 1 cycle to register the count, 1 cycle in EXIT_L0.
- Reset asserted mid-operation returns to OFF immediately, asynchronously; outputs drop to 0.

Test Plan:
- Reset, then start. Hold rx_idle_valid=rx_idle=1 continuously with back_pressure=0 -> l0_go pulses exactly once, once tx_cnt=16 and rx_cnt=8; busy then drops; timeout_go is never asserted.
- Same as above, but assert back_pressure every other cycle -> l0_go is delayed by 16 extra cycles versus the no-back-pressure run.
- 7 IDLEs received, then 1 non-IDLE, then continuous IDLEs -> rx counter restarts; exit occurs only after 8 new consecutive IDLEs.
- No rx IDLE ever, TIMEOUT_CYCLES=100 -> timeout_go pulses 100 cycles after ACTIVE entry; tx_cnt stays 0.
- Drive abort in ACTIVE with tx_cnt=10 -> next cycle OFF, no exit pulse; a following start restarts from 0 and asserts idl_clr.
- Make L0 criteria and timeout coincide in the same cycle -> only l0_go pulses. Assert rst mid-ACTIVE -> all outputs 0 immediately.
